// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port among NREQ writeback sources.
// A combinational round-robin arbiter grants one valid requester per cycle.
// The winning write is registered onto the register-file write interface.
// A 32-entry busy scoreboard tracks outstanding destination registers so
// decode can stall on RAW/WAW hazards.
//
// Optional feature, macro RF_ARB_BYPASS_EN:
//   Adds forwarding of the write being granted in the current cycle to the
//   decode source operands. A matching rsN_busy is forced low, and the
//   rsN_fwd_valid / rsN_fwd_data outputs carry the granted data.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/rd/data     per-requester writeback request (slice i per source)
//   req_ready             one-hot grant; a handshake is valid & ready
//   wr_en/addr/data       registered register-file write port
//   issue_valid/rd        decode issuing an instruction that writes issue_rd
//   issue_stall           WAW stall: issue_rd is already busy
//   rs1/rs2_addr          decode source operands
//   rs1/rs2_busy          scoreboard lookup for the sources (x0 never busy)
//   rs1/rs2_fwd_valid/data  same-cycle forwarding (RF_ARB_BYPASS_EN only)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [AW*NREQ-1:0]   req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_stall,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy
`ifdef RF_ARB_BYPASS_EN
  ,
  output logic                 rs1_fwd_valid,
  output logic [XLEN-1:0]      rs1_fwd_data,
  output logic                 rs2_fwd_valid,
  output logic [XLEN-1:0]      rs2_fwd_data
`endif
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   r_rr_ptr;
  logic [NREG-1:0] r_busy;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [XLEN-1:0] r_wr_data;

  logic            w_grant_found;
  logic [PW-1:0]   w_grant_idx;
  logic            w_accept;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [PW-1:0]   w_next_ptr;
  logic            w_issue_set;
  logic [NREG-1:0] w_busy_next;
  logic            w_rs1_hit;
  logic            w_rs2_hit;

  // Requester index reached after stepping k places from base, with wrap.
  function automatic int wrap_idx(input int base, input int k);
    return (base + k) % NREQ;
  endfunction

  // Round-robin scan: the first valid requester at or after r_rr_ptr wins.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_grant_found && req_valid[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = PW'(wrap_idx(int'(r_rr_ptr), k));
      end
    end
  end

  // Reset discards pending requests: no handshake can complete during reset.
  assign w_accept   = w_grant_found && !reset;
  assign req_ready  = w_accept ? (NREQ'(1) << w_grant_idx) : '0;
  assign w_sel_rd   = req_rd[AW*int'(w_grant_idx) +: AW];
  assign w_sel_data = req_data[XLEN*int'(w_grant_idx) +: XLEN];
  assign w_next_ptr = PW'((int'(w_grant_idx) + 1) % NREQ);

  assign issue_stall = issue_valid && (issue_rd != '0) && r_busy[issue_rd];
  assign w_issue_set = issue_valid && !issue_stall && (issue_rd != '0);

  // Clear for the accepted write is applied before the issue set, so a new
  // producer of the same register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_accept && (w_sel_rd != '0)) w_busy_next[w_sel_rd] = 1'b0;
    if (w_issue_set)                  w_busy_next[issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_rr_ptr  <= '0;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like
      // any other state; stale busy bits would stall decode forever.
      r_busy    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_busy  <= w_busy_next;
      // Writes to x0 complete the handshake but never reach the register file.
      r_wr_en <= w_accept && (w_sel_rd != '0);
      if (w_accept) begin
        r_wr_addr <= w_sel_rd;
        r_wr_data <= w_sel_data;
        r_rr_ptr  <= w_next_ptr;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef RF_ARB_BYPASS_EN
  assign w_rs1_hit = w_accept && (w_sel_rd != '0) && (w_sel_rd == rs1_addr);
  assign w_rs2_hit = w_accept && (w_sel_rd != '0) && (w_sel_rd == rs2_addr);
  assign rs1_fwd_valid = w_rs1_hit;
  assign rs2_fwd_valid = w_rs2_hit;
  assign rs1_fwd_data  = w_sel_data;
  assign rs2_fwd_data  = w_sel_data;
`else
  assign w_rs1_hit = 1'b0;
  assign w_rs2_hit = 1'b0;
`endif

  // busy[0] is held at zero, so x0 reads as not busy without a special case.
  assign rs1_busy = r_busy[rs1_addr] && !w_rs1_hit;
  assign rs2_busy = r_busy[rs2_addr] && !w_rs2_hit;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [AW*NREQ-1:0]   req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 issue_stall;
  logic [AW-1:0]        rs1_addr;
  logic [AW-1:0]        rs2_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
`ifdef RF_ARB_BYPASS_EN
  logic                 rs1_fwd_valid;
  logic [XLEN-1:0]      rs1_fwd_data;
  logic                 rs2_fwd_valid;
  logic [XLEN-1:0]      rs2_fwd_data;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
`ifdef RF_ARB_BYPASS_EN
    ,
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs2_fwd_data  (rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state of the arbiter as the rules state it.
  int              m_ptr;
  bit              m_busy [32];
  bit              m_wr_en;
  logic [AW-1:0]   m_wr_addr;
  logic [XLEN-1:0] m_wr_data;

  // Observations from the most recent cycle, for directed checks.
  int              last_grant;
  logic            obs_stall;
  logic            obs_rs1_busy;
  logic            obs_rs2_busy;
  logic [NREQ-1:0] obs_ready;
`ifdef RF_ARB_BYPASS_EN
  logic            obs_rs2_fwd_valid;
  logic [XLEN-1:0] obs_rs2_fwd_data;
`endif

  function automatic int model_grant();
    if (reset) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [AW-1:0] rd_of(input int i);
    return req_rd[AW*i +: AW];
  endfunction

  function automatic logic [XLEN-1:0] data_of(input int i);
    return req_data[XLEN*i +: XLEN];
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    req_valid[i] = 1'b1;
    req_rd[AW*i +: AW] = rd;
    req_data[XLEN*i +: XLEN] = d;
  endtask

  // One clock: check combinational outputs at negedge, advance the model at the
  // posedge, then check the registered outputs just after it.
  task automatic cycle();
    int   g;
    bit   stall_e;
    bit   hit1;
    bit   hit2;
    logic [AW-1:0] grd;
    @(negedge clk);
    g = model_grant();
    grd = (g >= 0) ? rd_of(g) : '0;
`ifdef RF_ARB_BYPASS_EN
    hit1 = (g >= 0) && (grd != 0) && (grd == rs1_addr);
    hit2 = (g >= 0) && (grd != 0) && (grd == rs2_addr);
`else
    hit1 = 0;
    hit2 = 0;
`endif
    stall_e = issue_valid && (issue_rd != 0) && m_busy[issue_rd];
    check("req_ready", req_ready, (g >= 0) ? (NREQ'(1) << g) : '0);
    check("issue_stall", issue_stall, stall_e);
    check("rs1_busy", rs1_busy, (rs1_addr != 0) && m_busy[rs1_addr] && !hit1);
    check("rs2_busy", rs2_busy, (rs2_addr != 0) && m_busy[rs2_addr] && !hit2);
`ifdef RF_ARB_BYPASS_EN
    check("rs1_fwd_valid", rs1_fwd_valid, hit1);
    check("rs2_fwd_valid", rs2_fwd_valid, hit2);
    if (hit1) check("rs1_fwd_data", rs1_fwd_data, data_of(g));
    if (hit2) check("rs2_fwd_data", rs2_fwd_data, data_of(g));
    obs_rs2_fwd_valid = rs2_fwd_valid;
    obs_rs2_fwd_data  = rs2_fwd_data;
`endif
    obs_stall    = issue_stall;
    obs_rs1_busy = rs1_busy;
    obs_rs2_busy = rs2_busy;
    obs_ready    = req_ready;
    @(posedge clk);
    if (reset) begin
      m_ptr = 0;
      foreach (m_busy[r]) m_busy[r] = 0;
      m_wr_en = 0;
      m_wr_addr = '0;
      m_wr_data = '0;
    end else begin
      m_wr_en = (g >= 0) && (grd != 0);
      if (g >= 0) begin
        m_wr_addr = grd;
        m_wr_data = data_of(g);
        m_ptr = (g + 1) % NREQ;
        if (grd != 0) m_busy[grd] = 0;
      end
      if (issue_valid && !stall_e && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_addr", wr_addr, m_wr_addr);
    check("wr_data", wr_data, m_wr_data);
    last_grant = g;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req_valid = '0;
  endtask

  int order [6];

  initial begin
    reset = 1'b1;
    req_rd = '0;
    req_data = '0;
    idle_inputs();
    m_ptr = 0;
    foreach (m_busy[r]) m_busy[r] = 0;
    m_wr_en = 0;
    m_wr_addr = '0;
    m_wr_data = '0;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, '0);

    // 1: issue x5, then requester 0 writes x5.
    issue_valid = 1'b1; issue_rd = 5; rs1_addr = 5;
    cycle();
    check("t1_issue_stall", obs_stall, 1'b0);
    issue_valid = 1'b0;
    set_req(0, 5, 32'hDEADBEEF);
    cycle();
`ifndef RF_ARB_BYPASS_EN
    check("t1_rs1_busy_pre", obs_rs1_busy, 1'b1);
`endif
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_wr_addr", wr_addr, 5);
    check("t1_wr_data", wr_data, 32'hDEADBEEF);
    cycle();
    check("t1_rs1_busy_post", obs_rs1_busy, 1'b0);
    check("t1_wr_en_pulse", wr_en, 1'b0);
    idle_inputs();

    // 2: three requesters valid continuously, pointer starting at 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'hA000_0000 + i);
    for (int c = 0; c < 6; c++) begin
      cycle();
      order[c] = last_grant;
      if (last_grant >= 0) set_req(last_grant, AW'(10 + last_grant), 32'hB000_0000 + c);
    end
    for (int c = 0; c < 6; c++) check("t2_order", order[c], c % 3);
    req_valid = '0;
    cycle();

    // 3: write to x0 completes, no wr_en, pointer moves to 2.
    set_req(1, 0, 32'h1234);
    cycle();
    check("t3_ready", obs_ready, 3'b010);
    check("t3_wr_en", wr_en, 1'b0);
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), 32'hC0 + i);
    cycle();
    check("t3_next_grant", last_grant, 2);
    req_valid = '0;
    cycle();

    // 4: WAW stall on x7, then simultaneous clear and new issue of x7.
    issue_valid = 1'b1; issue_rd = 7; rs1_addr = 7;
    cycle();
    cycle();
    check("t4_stall", obs_stall, 1'b1);
    issue_valid = 1'b0;
    set_req(0, 7, 32'h7777);
    cycle();
    set_req(1, 7, 32'h7778);
    issue_valid = 1'b1;
    cycle();
    check("t4_stall_free", obs_stall, 1'b0);
    issue_valid = 1'b0;
    cycle();
    check("t4_busy_kept", obs_rs1_busy, 1'b1);

    // 5: reset mid-operation with requests pending and busy bits set.
    issue_valid = 1'b1; issue_rd = 3;
    cycle();
    issue_rd = 9;
    cycle();
    issue_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(1 + i), 32'hF0 + i);
    reset = 1'b1;
    cycle();
    check("t5_ready", obs_ready, '0);
    check("t5_wr_en", wr_en, 1'b0);
    reset = 1'b0;
    rs1_addr = 3; rs2_addr = 9;
    cycle();
    check("t5_rs1_busy", obs_rs1_busy, 1'b0);
    check("t5_rs2_busy", obs_rs2_busy, 1'b0);
    check("t5_first_grant", last_grant, 0);
    idle_inputs();
    cycle();

`ifdef RF_ARB_BYPASS_EN
    // 6: same-cycle forwarding of a granted write.
    issue_valid = 1'b1; issue_rd = 4;
    cycle();
    issue_valid = 1'b0;
    rs2_addr = 4;
    set_req(2, 4, 32'hCAFE0001);
    cycle();
    check("t6_rs2_busy", obs_rs2_busy, 1'b0);
    check("t6_fwd_valid", obs_rs2_fwd_valid, 1'b1);
    check("t6_fwd_data", obs_rs2_fwd_data, 32'hCAFE0001);
    idle_inputs();
`endif

    // Random traffic; requesters hold their request until granted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom_range(31)), $urandom);
      issue_valid = ($urandom_range(1) == 1);
      issue_rd    = AW'($urandom_range(31));
      rs1_addr    = AW'($urandom_range(31));
      rs2_addr    = AW'($urandom_range(31));
      reset       = ($urandom_range(60) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port among NREQ writeback sources (ALU, load unit, CSR/mul) using a valid/ready handshake with round-robin grant. The winning write is registered and driven onto the register-file write interface (wr_en/wr_addr/wr_data). A 32-entry busy scoreboard tracks outstanding destination registers so decode can stall on RAW/WAW hazards. Sits between the execute/memory writeback sources, decode, and the register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register address width (32 registers)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  reset, synchronous, active-high
req_valid  in  NREQ  requester i has a writeback pending
req_rd  in  AW*NREQ  destination register of requester i (slice i = bits [AW*i +: AW])
req_data  in  XLEN*NREQ  write data of requester i
req_ready  out  NREQ  one-hot grant; handshake completes when valid & ready
wr_en  out  1  register-file write enable (registered)
wr_addr  out  AW  register-file write address (registered)
wr_data  out  XLEN  register-file write data (registered)
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  AW  destination register being issued
issue_stall  out  1  issue_valid & issue_rd!=0 & busy[issue_rd] (WAW); issue is not recorded when stalled
rs1_addr  in  AW  decode source 1
rs2_addr  in  AW  decode source 2
rs1_busy  out  1  busy[rs1_addr]; always 0 for x0
rs2_busy  out  1  busy[rs2_addr]; always 0 for x0

Behaviour:
- Reset (synchronous, posedge with reset=1): rr_ptr=0, busy=0, wr_en=0, wr_addr=0, wr_data=0. req_ready is 0 while reset=1. The reset value of issue_stall and rs*_busy follows the cleared busy vector (0).
- Arbitration is combinational. Starting at rr_ptr, grant the first i with req_valid[i]=1, scanning upward with wrap at NREQ-1 -> 0. req_ready is one-hot or zero, and is never asserted without req_valid.
- One write is accepted per cycle. The output register is loaded every cycle; no backpressure from the register file.
- Accept at posedge: wr_en<=1, wr_addr<=req_rd[g], wr_data<=req_data[g], rr_ptr<=(g+1) mod NREQ.
- No accept: wr_en<=0. wr_addr and wr_data hold. rr_ptr holds.
- Latency: handshake in cycle N -> wr_en high in cycle N+1 for exactly one cycle per accepted write.
- Writes to x0: the handshake completes, rr_ptr advances, and wr_en is still driven 0 for that write. The scoreboard is untouched.
- Scoreboard set: at posedge, if issue_valid & !issue_stall & issue_rd!=0, then busy[issue_rd]<=1.
- Scoreboard clear: at posedge, an accepted write clears busy[req_rd[g]].
- Simultaneous set and clear of the same register in one cycle: set wins, because the new producer owns the register.
- busy[0] is constantly 0.
- Requesters must hold req_valid, req_rd and req_data stable until granted. Behaviour when they drop early is undefined.
- Reset mid-operation: pending requests are discarded (req_ready=0 during reset), the in-flight wr_en is cleared, and all busy bits are cleared.

Optional Feature:
Macro RF_ARB_BYPASS_EN.
- When defined: if the request granted this cycle targets rs1_addr (or rs2_addr, nonzero), rsN_busy is forced 0 and extra outputs become active:
  - rs1_fwd_valid / rs2_fwd_valid (1 bit each)
  - rs1_fwd_data / rs2_fwd_data (XLEN each), carrying the granted req_data
  - This lets decode issue in the grant cycle.
- When undefined: the fwd ports do not exist, and rsN_busy reflects the busy vector only.

Test Plan:
1. Reset, then issue x5, then req0 writes x5=0xDEADBEEF -> issue_stall=0. rs1_busy(rs1=5)=1 until the grant edge. Next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, and busy[5]=0.
2. All three req_valid high continuously for 6 cycles, rr_ptr=0 -> grant order 0,1,2,0,1,2, each wr_en pulse carrying the matching data.
3. req1 writes x0=0x1234 -> req_ready[1]=1, next cycle wr_en=0, rr_ptr=2.
4. Issue x7 while busy[7]=1 -> issue_stall=1, busy unchanged. In the same cycle as an accepted write to x7 plus a new issue of x7 -> busy[7] stays 1.
5. Assert reset with req_valid=3'b111 and busy[3]=busy[9]=1 -> req_ready=0, next cycle wr_en=0, busy all 0, rr_ptr=0.
6. With RF_ARB_BYPASS_EN: busy[4]=1, req2 granted for x4=0xCAFE0001, rs2_addr=4 -> rs2_busy=0, rs2_fwd_valid=1, rs2_fwd_data=0xCAFE0001 in the same cycle.
